// File: rtl/bpsk_demodulator.sv
// Coherent BPSK symbol correlator: multiplies each sample by the local
// reference carrier, integrates over one carrier period and decides a bit.
// Ports:
//   clk, arstn         clock, async active-low reset
//   en                 sample strobe qualifying sample_in/ref_in/ref_cnt
//   sample_in, ref_in  signed received and reference samples
//   ref_cnt            phase index of ref_in
//   bit_out, corr_out  last decision and its correlation (held)
//   bit_valid          one-cycle pulse on a new decision
//   sync_err           one-cycle pulse when a phase jump aborts a symbol
//   locked             high while integrating a symbol
//   sym_cnt            number of decided bits (wrapping)
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  localparam int CNT_W = $clog2(SAMPLE_NUMBER),
  localparam int ACC_W = 2*SAMPLE_WIDTH+CNT_W
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           en,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic signed [SAMPLE_WIDTH-1:0] ref_in,
  input  logic        [CNT_W-1:0]        ref_cnt,
  output logic                           bit_out,
  output logic                           bit_valid,
  output logic signed [ACC_W-1:0]        corr_out,
  output logic                           sync_err,
  output logic                           locked,
  output logic        [15:0]             sym_cnt
);

  localparam int PROD_W = 2*SAMPLE_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_NUMBER-1);

  typedef enum logic {S_IDLE, S_INTEG} state_t;

  state_t r_state;
  state_t w_state_n;

  logic signed [PROD_W-1:0] r_prod;
  logic                     r_vld;
  logic                     r_first;
  logic                     r_last;
  logic [CNT_W-1:0]         r_idx;
  logic [CNT_W-1:0]         r_prev_idx;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_n;
  logic                     w_contig;
  logic                     w_dec;
  logic                     w_serr;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_prod  <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_prod  <= sample_in * ref_in;
      r_vld   <= en;
      r_first <= en & (ref_cnt == '0);
      r_last  <= en & (ref_cnt == LAST_IDX);
      r_idx   <= ref_cnt;
    end
  end

  assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Index arithmetic wraps at CNT_W bits, i.e. modulo SAMPLE_NUMBER.
  assign w_contig   = (r_idx == r_prev_idx + CNT_W'(1));

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_dec     = 1'b0;
    w_serr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_vld && r_first) begin
          w_acc_n   = w_prod_ext;
          w_state_n = S_INTEG;
        end
      end
      S_INTEG: begin
        if (!r_vld) begin
          w_state_n = S_IDLE;
        end else if (!w_contig) begin
          // A fresh period start restarts integration in place.
          w_serr = 1'b1;
          if (r_first) begin
            w_acc_n = w_prod_ext;
          end else begin
            w_state_n = S_IDLE;
          end
        end else if (r_last) begin
          w_dec     = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_acc_n = w_sum;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_prev_idx <= '0;
      bit_valid  <= 1'b0;
      sync_err   <= 1'b0;
      bit_out    <= 1'b0;
      corr_out   <= '0;
      sym_cnt    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_acc      <= w_acc_n;
      r_prev_idx <= r_idx;
      bit_valid  <= w_dec;
      sync_err   <= w_serr;
      if (w_dec) begin
        corr_out <= w_sum;
        bit_out  <= ~w_sum[ACC_W-1];
        sym_cnt  <= sym_cnt + 16'd1;
      end
    end
  end

  assign locked = (r_state == S_INTEG);

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator with a cycle-stamped scoreboard
// of expected decisions and sync errors.
module tb_bpsk_demodulator;

  logic               clk = 1'b0;
  logic               arstn = 1'b0;
  logic               en = 1'b0;
  logic signed [11:0] sample_in = '0;
  logic signed [11:0] ref_in = '0;
  logic        [7:0]  ref_cnt = '0;
  logic               bit_out;
  logic               bit_valid;
  logic signed [31:0] corr_out;
  logic               sync_err;
  logic               locked;
  logic        [15:0] sym_cnt;

  bpsk_demodulator dut (
    .clk(clk), .arstn(arstn), .en(en),
    .sample_in(sample_in), .ref_in(ref_in), .ref_cnt(ref_cnt),
    .bit_out(bit_out), .bit_valid(bit_valid), .corr_out(corr_out),
    .sync_err(sync_err), .locked(locked), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             b;
    logic signed [31:0] corr;
    logic [15:0]      sc;
  } exp_t;

  exp_t q[$];
  int   se_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_sym = 0;

  task automatic chk(input string tag, input longint obs,
                     input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
             tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input logic e, input int s, input int r,
                      input int c);
    exp_t x;
    logic exp_bv;
    logic exp_se;
    en        = e;
    sample_in = 12'(s);
    ref_in    = 12'(r);
    ref_cnt   = 8'(c);
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_bit_valid", 0, 1);
      void'(q.pop_front());
    end
    while (se_q.size() > 0 && se_q[0] < cyc) begin
      chk("missed_sync_err", 0, 1);
      void'(se_q.pop_front());
    end
    exp_bv = (q.size() > 0 && q[0].cyc == cyc);
    exp_se = (se_q.size() > 0 && se_q[0] == cyc);
    chk("bit_valid", bit_valid, exp_bv);
    chk("sync_err", sync_err, exp_se);
    if (exp_bv) begin
      x = q.pop_front();
      chk("bit_out", bit_out, x.b);
      chk("corr_out", corr_out, x.corr);
      chk("sym_cnt", sym_cnt, x.sc);
    end
    if (exp_se) void'(se_q.pop_front());
  endtask

  // Drives ref_cnt start..255 at constant levels; a full period
  // queues its expected decision.
  task automatic run_sym(input int s, input int r, input int start);
    exp_t x;
    for (int c = start; c < 256; c++) begin
      if (c == 255 && start == 0) begin
        exp_sym++;
        x.cyc  = cyc + 2;
        x.corr = 32'(longint'(256) * s * r);
        x.b    = (x.corr >= 0);
        x.sc   = 16'(exp_sym);
        q.push_back(x);
      end
      step(1'b1, s, r, c);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bit_out"}, bit_out, 0);
    chk({tag, "_bit_valid"}, bit_valid, 0);
    chk({tag, "_corr_out"}, corr_out, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sym_cnt"}, sym_cnt, 0);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    en    = 1'b0;
    q.delete();
    se_q.delete();
    exp_sym = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    arstn = 1'b1;
  endtask

  initial begin
    do_reset();
    check_zero("reset");

    run_sym(100, 100, 0);
    run_sym(-100, 100, 0);
    run_sym(0, 100, 0);
    repeat (3) step(1'b0, 0, 0, 0);

    do_reset();
    run_sym(100, 100, 100);
    run_sym(100, 100, 0);
    run_sym(-100, 100, 0);
    run_sym(100, 100, 0);
    repeat (3) step(1'b0, 0, 0, 0);

    for (int c = 0; c < 256; c++) begin
      step(c != 50, 100, 100, c);
      if (c == 49) chk("locked_before_drop", locked, 1);
      if (c == 51) chk("locked_after_drop", locked, 0);
    end
    run_sym(100, -100, 0);
    repeat (2) step(1'b0, 0, 0, 0);

    for (int c = 0; c < 256; c++) begin
      if (c == 11) continue;
      if (c == 12) se_q.push_back(cyc + 2);
      step(1'b1, 70, 70, c);
      if (c == 10) chk("locked_before_jump", locked, 1);
      if (c == 14) chk("locked_after_jump", locked, 0);
    end
    run_sym(50, 50, 0);
    repeat (2) step(1'b0, 0, 0, 0);

    for (int c = 0; c < 128; c++) step(1'b1, 100, 100, c);
    chk("locked_pre_reset", locked, 1);
    arstn = 1'b0;
    #1;
    check_zero("midreset");
    q.delete();
    se_q.delete();
    exp_sym = 0;
    step(1'b1, 100, 100, 128);
    step(1'b1, 100, 100, 129);
    arstn = 1'b1;
    run_sym(100, 100, 130);
    run_sym(-2048, -2048, 0);
    repeat (4) step(1'b0, 0, 0, 0);

    chk("pending_bits", q.size(), 0);
    chk("pending_sync_err", se_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
